// File: rtl/reg_sb_pkg.sv
// Register scoreboard shared types, default sizes
// and forwarding encodings.
package reg_sb_pkg;

   localparam int DEF_NUM_REGS   = 32;
   localparam int DEF_REG_W      = 5;
   localparam int DEF_NUM_STAGES = 3;

   localparam logic [1:0] FWD_NONE = 2'd0;

   typedef logic [DEF_REG_W-1:0] regIdx_t;

   function automatic logic [DEF_NUM_REGS-1:0] onehot(input regIdx_t idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/reg_sb_pend.sv
// Per-register outstanding long-latency write counters
// with a sticky underflow error flag.
module reg_sb_pend #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int PEND_W   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                incEn,
   input  logic [REG_W-1:0]    incRd,
   input  logic                decEn,
   input  logic [REG_W-1:0]    decRd,
   output logic [NUM_REGS-1:0] busy,
   output logic [NUM_REGS-1:0] full,
   output logic                err
);

   localparam logic [PEND_W-1:0] CntMax = '1;

   logic [PEND_W-1:0] cnt [NUM_REGS];
   logic              sameReg;
   logic              errSet;

   // A matching increment cancels the decrement, so no underflow then.
   assign sameReg = incEn && (incRd == decRd);
   assign errSet  = decEn && !sameReg && (cnt[decRd] == '0);

   always_comb begin
      busy = '0;
      full = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy[r] = (cnt[r] != '0);
         full[r] = (cnt[r] == CntMax);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
         err <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (incEn && incRd == REG_W'(r) &&
                !(decEn && decRd == REG_W'(r)) &&
                cnt[r] != CntMax)
               cnt[r] <= cnt[r] + 1'b1;
            else if (decEn && decRd == REG_W'(r) &&
                     !(incEn && incRd == REG_W'(r)) &&
                     cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
         end
         if (errSet) err <= 1'b1;
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-usage scoreboard: stage tracking, forwarding
// selects, load-use / long-latency stall.
module reg_scoreboard
   import reg_sb_pkg::*;
#(
   parameter int NUM_REGS       = DEF_NUM_REGS,
   parameter int REG_W          = DEF_REG_W,
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int ZERO_HARDWIRED = 1,
   parameter int PEND_W         = 2,
   parameter int FSEL_W         = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           hold_i,
   input  logic                           flush_i,
   input  logic                           issue_valid_i,
   input  logic [REG_W-1:0]               issue_rd_i,
   input  logic                           issue_wb_i,
   input  logic                           issue_ld_i,
   input  logic                           issue_long_i,
   input  logic [REG_W-1:0]               rs_i,
   input  logic [REG_W-1:0]               rt_i,
   input  logic                           rs_used_i,
   input  logic                           rt_used_i,
   input  logic                           long_done_i,
   input  logic [REG_W-1:0]               long_done_rd_i,
   output logic                           issue_acc_o,
   output logic                           stall_o,
   output logic [NUM_STAGES*NUM_REGS-1:0] stage_mask_o,
   output logic [NUM_REGS-1:0]            busy_mask_o,
   output logic [FSEL_W-1:0]              fwd_rs_o,
   output logic [FSEL_W-1:0]              fwd_rt_o,
   output logic                           err_o
);

   logic [NUM_STAGES-1:0] stgVld;
   logic [NUM_STAGES-1:0] stgWb;
   logic [NUM_STAGES-1:0] stgLd;
   logic [REG_W-1:0]      stgRd   [NUM_STAGES];
   logic [NUM_REGS-1:0]   stgMask [NUM_STAGES];

   logic [NUM_REGS-1:0] pendBusy;
   logic [NUM_REGS-1:0] pendFull;
   logic                pendInc;
   logic                ldHit;
   logic                pendHit;

   always_comb begin
      stage_mask_o = '0;
      busy_mask_o  = pendBusy;
      for (int s = 0; s < NUM_STAGES; s++) begin
         stgMask[s] = '0;
         if (stgVld[s] && stgWb[s] &&
             !(ZERO_HARDWIRED != 0 && stgRd[s] == '0))
            stgMask[s] = NUM_REGS'(onehot(regIdx_t'(stgRd[s])));
         stage_mask_o[s*NUM_REGS +: NUM_REGS] = stgMask[s];
         busy_mask_o = busy_mask_o | stgMask[s];
      end
   end

   // Walk oldest to youngest so the youngest hit wins.
   always_comb begin
      fwd_rs_o = FSEL_W'(FWD_NONE);
      fwd_rt_o = FSEL_W'(FWD_NONE);
      for (int s = NUM_STAGES-1; s >= 0; s--) begin
         if (rs_used_i && stgMask[s][rs_i]) fwd_rs_o = FSEL_W'(s+1);
         if (rt_used_i && stgMask[s][rt_i]) fwd_rt_o = FSEL_W'(s+1);
      end
   end

   assign ldHit   = stgLd[0] &&
                    ((rs_used_i && stgMask[0][rs_i]) ||
                     (rt_used_i && stgMask[0][rt_i]));
   assign pendHit = (rs_used_i && pendBusy[rs_i]) ||
                    (rt_used_i && pendBusy[rt_i]);

   assign stall_o = issue_valid_i &&
                    (ldHit || pendHit ||
                     (issue_long_i && pendFull[issue_rd_i]));

   assign issue_acc_o = issue_valid_i && !stall_o && !hold_i && !flush_i;

   assign pendInc = issue_acc_o && issue_long_i && issue_wb_i &&
                    !(ZERO_HARDWIRED != 0 && issue_rd_i == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stgVld <= '0;
         stgWb  <= '0;
         stgLd  <= '0;
         for (int s = 0; s < NUM_STAGES; s++) stgRd[s] <= '0;
      end else if (flush_i) begin
         stgVld <= '0;
      end else if (!hold_i) begin
         for (int s = NUM_STAGES-1; s > 0; s--) begin
            stgVld[s] <= stgVld[s-1];
            stgWb[s]  <= stgWb[s-1];
            stgLd[s]  <= stgLd[s-1];
            stgRd[s]  <= stgRd[s-1];
         end
         stgVld[0] <= issue_acc_o && !issue_long_i;
         stgWb[0]  <= issue_wb_i;
         stgLd[0]  <= issue_ld_i;
         stgRd[0]  <= issue_rd_i;
      end
   end

   reg_sb_pend #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W),
      .PEND_W   (PEND_W)
   ) uPend (
      .clk   (clk),
      .rst_n (rst_n),
      .incEn (pendInc),
      .incRd (issue_rd_i),
      .decEn (long_done_i),
      .decRd (long_done_rd_i),
      .busy  (pendBusy),
      .full  (pendFull),
      .err   (err_o)
   );

endmodule
